// File: rtl/i2s_tx.sv
// i2s_tx: stereo 16-bit PCM to I2S serialiser. Everything runs on clk; the
// bit clock, word select and data pins are register outputs.
// Optional build macro I2S_TX_PHILIPS_DELAY_EN: data lags word select by one
// bclk (Philips I2S). Left undefined, the stream is left-justified.
// SLOT_WIDTH must be >= 16 (samples are MSB-aligned, zero-padded below).
module i2s_tx #(
  parameter int unsigned BCLK_HALF  = 12,
  parameter int unsigned SLOT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [15:0] i_sampleLeft,
  input  logic [15:0] i_sampleRight,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_frameStart,
  output logic [15:0] o_underrunCount,
  output logic        audio_bclk,
  output logic        audio_lrclk,
  output logic        audio_din
);

  localparam int unsigned FRAME_W = 2 * SLOT_WIDTH;
  localparam int unsigned DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bitcnt;
  logic                  r_bclk;
  logic                  r_lrclk;
  logic                  r_din;
  logic                  r_ready;
  logic                  r_full;
  logic                  r_frameStart;
  logic [15:0]           r_holdL;
  logic [15:0]           r_holdR;
  logic [15:0]           r_underrun;
  logic [FRAME_W-1:0]    r_shift;

  logic                  w_tc;
  logic                  w_fall;
  logic                  w_wrap;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_newBit;
  logic                  w_dinNext;
  logic                  w_lrNext;
  logic [BIT_W-1:0]      w_bitNext;
  logic [SLOT_WIDTH-1:0] w_slotL;
  logic [SLOT_WIDTH-1:0] w_slotR;
  logic [FRAME_W-1:0]    w_frame;

`ifdef I2S_TX_PHILIPS_DELAY_EN
  logic                  r_dly;
`endif

  // Divider / bit-boundary decode and assembly of the next frame word
  always_comb begin
    w_tc      = (r_div == DIV_W'(BCLK_HALF - 1));
    w_fall    = (r_state == ST_RUN) && i_enable && w_tc && r_bclk;
    w_wrap    = w_fall && (r_bitcnt == BIT_W'(FRAME_W - 1));
    w_load    = (r_state == ST_LOAD) || w_wrap;
    w_accept  = i_valid && r_ready;
    w_bitNext = w_wrap ? '0 : r_bitcnt + BIT_W'(1);
    w_lrNext  = (w_bitNext >= BIT_W'(SLOT_WIDTH));
    w_slotL   = SLOT_WIDTH'(r_holdL) << (SLOT_WIDTH - 16);
    w_slotR   = SLOT_WIDTH'(r_holdR) << (SLOT_WIDTH - 16);
    // Holding is never cleared on load, so once drained it still holds the
    // last frame sent: an underrun reload and a normal load share this path.
    w_frame   = {w_slotL, w_slotR};
    w_newBit  = w_load ? w_frame[FRAME_W-1] : r_shift[FRAME_W-1];
`ifdef I2S_TX_PHILIPS_DELAY_EN
    w_dinNext = r_dly;
`else
    w_dinNext = w_newBit;
`endif
  end

`ifdef I2S_TX_PHILIPS_DELAY_EN
  // One-bit data delay, advanced on every bclk fall and on frame load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dly <= 1'b0;
    end else if (r_state == ST_IDLE || (r_state == ST_RUN && !i_enable)) begin
      r_dly <= 1'b0;
    end else if (r_state == ST_LOAD || w_fall) begin
      r_dly <= w_newBit;
    end
  end
`endif

  // Handshake, holding register, shifter, underrun counter and serial FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_bitcnt     <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_din        <= 1'b0;
      r_ready      <= 1'b1;
      r_full       <= 1'b0;
      r_frameStart <= 1'b0;
      r_holdL      <= '0;
      r_holdR      <= '0;
      r_underrun   <= '0;
      r_shift      <= '0;
    end else begin
      r_frameStart <= w_load;

      if (w_accept) begin
        r_holdL <= i_sampleLeft;
        r_holdR <= i_sampleRight;
        r_full  <= 1'b1;
        r_ready <= 1'b0;
      end else if (w_load && r_full) begin
        r_full  <= 1'b0;
        r_ready <= 1'b1;
      end

      if (w_load) begin
        r_shift <= w_frame << 1;
        if (!r_full && r_underrun != '1) begin
          r_underrun <= r_underrun + 16'd1;
        end
      end else if (w_fall) begin
        r_shift <= r_shift << 1;
      end

      case (r_state)
        ST_IDLE: begin
          r_div    <= '0;
          r_bitcnt <= '0;
          r_bclk   <= 1'b0;
          r_lrclk  <= 1'b0;
          r_din    <= 1'b0;
          if (i_enable) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_div    <= '0;
          r_bitcnt <= '0;
          r_bclk   <= 1'b0;
          r_lrclk  <= 1'b0;
          r_din    <= w_dinNext;
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          if (!i_enable) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_bclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_din    <= 1'b0;
          end else begin
            if (w_tc) begin
              r_div  <= '0;
              r_bclk <= ~r_bclk;
            end else begin
              r_div  <= r_div + DIV_W'(1);
            end
            if (w_fall) begin
              r_bitcnt <= w_bitNext;
              r_lrclk  <= w_lrNext;
              r_din    <= w_dinNext;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready         = r_ready;
  assign o_frameStart    = r_frameStart;
  assign o_underrunCount = r_underrun;
  assign audio_bclk      = r_bclk;
  assign audio_lrclk     = r_lrclk;
  assign audio_din       = r_din;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx against a time-indexed model of
// the serial stream (frame/bit position derived from cycles since LOAD).
module tb_i2s_tx;

  localparam int unsigned BH         = 12;
  localparam int unsigned SW         = 16;
  localparam int unsigned BIT_CLKS   = 2 * BH;
  localparam int unsigned FRAME_CLKS = 2 * SW * BIT_CLKS;
`ifdef I2S_TX_PHILIPS_DELAY_EN
  localparam bit PHIL = 1'b1;
`else
  localparam bit PHIL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_enable = 1'b0;
  logic [15:0] i_sampleLeft = '0;
  logic [15:0] i_sampleRight = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_frameStart;
  logic [15:0] o_underrunCount;
  logic        audio_bclk;
  logic        audio_lrclk;
  logic        audio_din;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] frames[$];
  logic [15:0] cnts[$];

  always #5 clk = ~clk;

  i2s_tx #(.BCLK_HALF(BH), .SLOT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_sampleLeft(i_sampleLeft), .i_sampleRight(i_sampleRight),
    .i_valid(i_valid), .o_ready(o_ready), .o_frameStart(o_frameStart),
    .o_underrunCount(o_underrunCount), .audio_bclk(audio_bclk),
    .audio_lrclk(audio_lrclk), .audio_din(audio_din)
  );

  // Expected {frameStart, bclk, lrclk, din} at t cycles after the LOAD edge.
  function automatic logic [3:0] model_pins(int unsigned t, logic [31:0] cur,
                                            logic [31:0] prev);
    int unsigned b;
    logic fs, bc, lr, d;
    b  = (t / BIT_CLKS) % (2 * SW);
    fs = (t % FRAME_CLKS) == 0;
    bc = ((t / BH) % 2) == 1;
    lr = b >= SW;
    if (PHIL) begin
      if (b == 0) d = prev[0];
      else        d = cur[32 - b];
    end else begin
      d = cur[31 - b];
    end
    return {fs, bc, lr, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_enable = 1'b0;
    i_valid  = 1'b0;
    rst      = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push_idle(logic [31:0] p);
    i_valid = 1'b1;
    {i_sampleLeft, i_sampleRight} = p;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic start_run();
    i_enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_pins got=%b exp=10000",
               {o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din});
    end
    n_cmp++;
    if (o_underrunCount !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count got=%0d exp=0", o_underrunCount);
    end
    rst = 1'b1;
    for (int unsigned i = 0; i < 5; i++) tick();
    n_cmp++;
    if ({o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din} !== 5'b10000) begin
      n_err++;
      $display("FAIL idle_pins got=%b exp=10000",
               {o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din});
    end
  endtask

  task automatic test_underrun();
    int unsigned fi;
    logic [3:0] ex;
    do_reset();
    frames = '{32'h0, 32'h0, 32'h0};
    cnts   = '{16'd1, 16'd2, 16'd3};
    start_run();
    for (int unsigned t = 0; t < 3 * FRAME_CLKS; t++) begin
      fi = t / FRAME_CLKS;
      ex = model_pins(t, frames[fi], 32'h0);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL underrun_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t % FRAME_CLKS == 0) begin
        n_cmp++;
        if (o_underrunCount !== cnts[fi]) begin
          n_err++;
          $display("FAIL underrun_count t=%0d got=%0d exp=%0d", t, o_underrunCount, cnts[fi]);
        end
      end
      tick();
    end
  endtask

  task automatic test_basic();
    int unsigned fi;
    logic [3:0] ex;
    do_reset();
    frames = '{32'hA5C3_0F81, 32'hA5C3_0F81};
    cnts   = '{16'd0, 16'd1};
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_ready_pre got=%b exp=1", o_ready);
    end
    push_idle(frames[0]);
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_ready_full got=%b exp=0", o_ready);
    end
    start_run();
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_ready_load got=%b exp=1", o_ready);
    end
    for (int unsigned t = 0; t < 2 * FRAME_CLKS; t++) begin
      fi = t / FRAME_CLKS;
      ex = model_pins(t, frames[fi], (fi == 0) ? 32'h0 : frames[fi-1]);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL basic_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t % FRAME_CLKS == 0) begin
        n_cmp++;
        if (o_underrunCount !== cnts[fi]) begin
          n_err++;
          $display("FAIL basic_count t=%0d got=%0d exp=%0d", t, o_underrunCount, cnts[fi]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int unsigned fi, nxt, off;
    logic [3:0] ex;
    logic xfer;
    do_reset();
    frames = '{32'h8000_7FFF, 32'h7FFF_8000, 32'($urandom), 32'($urandom)};
    cnts   = '{16'd0, 16'd0, 16'd0, 16'd0};
    push_idle(frames[0]);
    start_run();
    nxt = 1;
    off = $urandom_range(1, 700);
    for (int unsigned t = 0; t < 4 * FRAME_CLKS; t++) begin
      fi = t / FRAME_CLKS;
      ex = model_pins(t, frames[fi], (fi == 0) ? 32'h0 : frames[fi-1]);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL stream_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t % FRAME_CLKS == 0) begin
        n_cmp++;
        if (o_underrunCount !== cnts[fi]) begin
          n_err++;
          $display("FAIL stream_count t=%0d got=%0d exp=%0d", t, o_underrunCount, cnts[fi]);
        end
      end
      if (nxt < 4 && nxt == fi + 1 && (t % FRAME_CLKS) == off) begin
        i_valid = 1'b1;
        {i_sampleLeft, i_sampleRight} = frames[nxt];
      end
      xfer = i_valid && o_ready;
      tick();
      if (xfer) begin
        i_valid = 1'b0;
        nxt++;
        off = $urandom_range(1, 700);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned fi;
    logic [3:0] ex;
    logic xfer;
    do_reset();
    frames = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h0BAD_BEEF, 32'hFACE_0001};
    cnts   = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
    push_idle(frames[0]);
    start_run();
    for (int unsigned t = 0; t < 5 * FRAME_CLKS; t++) begin
      fi = t / FRAME_CLKS;
      ex = model_pins(t, frames[fi], (fi == 0) ? 32'h0 : frames[fi-1]);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL b2b_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t % FRAME_CLKS == 0) begin
        n_cmp++;
        if (o_underrunCount !== cnts[fi]) begin
          n_err++;
          $display("FAIL b2b_count t=%0d got=%0d exp=%0d", t, o_underrunCount, cnts[fi]);
        end
      end
      if (t == 766 || t == 769) begin
        n_cmp++;
        if (o_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_ready t=%0d got=%b exp=0", t, o_ready);
        end
      end
      if (t == 0) begin
        i_valid = 1'b1;
        {i_sampleLeft, i_sampleRight} = frames[1];
      end else if (t == 760) begin
        i_valid = 1'b1;
        {i_sampleLeft, i_sampleRight} = frames[2];
      end else if (t == 3 * FRAME_CLKS - 1) begin
        i_valid = 1'b1;
        {i_sampleLeft, i_sampleRight} = frames[4];
      end
      xfer = i_valid && o_ready;
      tick();
      if (xfer) i_valid = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    int unsigned fi;
    logic [3:0] ex;
    logic [31:0] p0, p1;
    do_reset();
    p0 = 32'($urandom);
    p1 = 32'($urandom) | 32'h8000_0001;
    push_idle(p0);
    start_run();
    for (int unsigned t = 0; t <= 484; t++) begin
      ex = model_pins(t, p0, 32'h0);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL drop_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t == 10) begin
        i_valid = 1'b1;
        {i_sampleLeft, i_sampleRight} = p1;
      end
      if (t == 11) i_valid = 1'b0;
      if (t < 484) tick();
    end
    i_enable = 1'b0;
    tick();
    n_cmp++;
    if ({o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din} !== 5'b00000) begin
      n_err++;
      $display("FAIL drop_idle got=%b exp=00000",
               {o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din});
    end
    for (int unsigned i = 0; i < 5; i++) tick();
    frames = '{p1, p1};
    cnts   = '{16'd0, 16'd1};
    start_run();
    for (int unsigned t = 0; t < FRAME_CLKS + 300; t++) begin
      fi = t / FRAME_CLKS;
      ex = model_pins(t, frames[fi], (fi == 0) ? 32'h0 : frames[fi-1]);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL reenable_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t % FRAME_CLKS == 0) begin
        n_cmp++;
        if (o_underrunCount !== cnts[fi]) begin
          n_err++;
          $display("FAIL reenable_count t=%0d got=%0d exp=%0d", t, o_underrunCount, cnts[fi]);
        end
      end
      tick();
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din, o_underrunCount}
        !== {5'b10000, 16'd0}) begin
      n_err++;
      $display("FAIL async_reset got=%b cnt=%0d exp=10000 cnt=0",
               {o_ready, o_frameStart, audio_bclk, audio_lrclk, audio_din}, o_underrunCount);
    end
    i_enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_run();
    for (int unsigned t = 0; t < FRAME_CLKS; t++) begin
      ex = model_pins(t, 32'h0, 32'h0);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL discard_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t == 0) begin
        n_cmp++;
        if (o_underrunCount !== 16'd1) begin
          n_err++;
          $display("FAIL discard_count got=%0d exp=1", o_underrunCount);
        end
      end
      tick();
    end
  endtask

  task automatic test_pattern_8001();
    int unsigned fi;
    logic [3:0] ex;
    do_reset();
    frames = '{32'h8001_0000, 32'h8001_0000};
    push_idle(frames[0]);
    start_run();
    for (int unsigned t = 0; t < 2 * FRAME_CLKS; t++) begin
      fi = t / FRAME_CLKS;
      ex = model_pins(t, frames[fi], (fi == 0) ? 32'h0 : frames[fi-1]);
      n_cmp++;
      if ({o_frameStart, audio_bclk, audio_lrclk, audio_din} !== ex) begin
        n_err++;
        $display("FAIL p8001_pins t=%0d got=%b exp=%b", t,
                 {o_frameStart, audio_bclk, audio_lrclk, audio_din}, ex);
        break;
      end
      if (t == 5) begin
        n_cmp++;
        if (audio_din !== !PHIL) begin
          n_err++;
          $display("FAIL p8001_left_bit0 got=%b exp=%b", audio_din, !PHIL);
        end
      end
      if (t == BIT_CLKS + 5 || t == SW * BIT_CLKS + 5) begin
        n_cmp++;
        if (audio_din !== PHIL) begin
          n_err++;
          $display("FAIL p8001_bit t=%0d got=%b exp=%b", t, audio_din, PHIL);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_basic();
    test_stream();
    test_back_to_back();
    test_enable_drop();
    test_pattern_8001();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
